// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver states, word length decode and the
// parity rule used by both transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Line configuration captured at the start bit and held for the whole frame
    typedef struct packed {
        logic       pen;
        logic       eps;
        logic       sticky;
        logic [1:0] wls;
    } line_cfg_t;

    function automatic logic [3:0] word_len(input logic [1:0] wls);
        return 4'd5 + {2'b00, wls};
    endfunction

    // Unused upper data bits must be zero for the XOR reduction to be correct
    function automatic logic parity_bit(input logic [7:0] data,
                                        input logic       eps,
                                        input logic       sticky);
        logic p;
        if (sticky)
            p = ~eps;
        else if (eps)
            p = ^data;
        else
            p = ~^data;
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous serial line into the clk domain and flags falling
// edges of the synchronised line.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Flops reset to the idle-high level so leaving reset never looks like a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign fall = prev_q & ~rx_s;

endmodule

// File: rtl/uart_rx_top.sv
// 16550-style serial receiver: start detection, mid-bit sampling of data,
// parity and stop, and one push per frame with pe/fe/bi status.
module uart_rx_top #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       rx,
    input  logic       pen,
    input  logic       eps,
    input  logic       sticky_parity,
    input  logic [1:0] wls,
    output logic       push,
    output logic [7:0] dout,
    output logic       pe,
    output logic       fe,
    output logic       bi
);

    import uart_pkg::*;

    localparam int            CW   = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);

    logic rx_s;
    logic fall;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .rx_s(rx_s),
        .fall(fall)
    );

    rx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bitn, bitn_n;
    logic [7:0]    shift, shift_n;
    line_cfg_t     cfg, cfg_n;
    logic          par_q, par_n;
    logic          push_n;
    logic [7:0]    dout_n;
    logic          pe_n, fe_n, bi_n;
    line_cfg_t     cfg_in;
    logic          last_bit;

    assign cfg_in   = '{pen: pen, eps: eps, sticky: sticky_parity, wls: wls};
    assign last_bit = ({1'b0, bitn} == (word_len(cfg.wls) - 4'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            bitn  <= '0;
            shift <= '0;
            cfg   <= '0;
            par_q <= 1'b0;
            push  <= 1'b0;
            dout  <= '0;
            pe    <= 1'b0;
            fe    <= 1'b0;
            bi    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bitn  <= bitn_n;
            shift <= shift_n;
            cfg   <= cfg_n;
            par_q <= par_n;
            push  <= push_n;
            dout  <= dout_n;
            pe    <= pe_n;
            fe    <= fe_n;
            bi    <= bi_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bitn_n  = bitn;
        shift_n = shift;
        cfg_n   = cfg;
        par_n   = par_q;
        push_n  = 1'b0;
        dout_n  = dout;
        pe_n    = pe;
        fe_n    = fe;
        bi_n    = bi;

        case (state)
            IDLE: begin
                if (fall) begin
                    state_n = START;
                    cnt_n   = '0;
                    cfg_n   = cfg_in;
                end
            end

            START: begin
                if (baud_pulse) begin
                    if (cnt == HALF) begin
                        cnt_n = '0;
                        if (rx_s) begin
                            state_n = IDLE;
                        end else begin
                            state_n = DATA;
                            bitn_n  = '0;
                            shift_n = '0;
                            par_n   = 1'b0;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end

            DATA: begin
                if (baud_pulse) begin
                    if (cnt == FULL) begin
                        cnt_n         = '0;
                        shift_n[bitn] = rx_s;
                        if (last_bit)
                            state_n = cfg.pen ? PARITY : STOP;
                        else
                            bitn_n = bitn + 3'd1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end

            PARITY: begin
                if (baud_pulse) begin
                    if (cnt == FULL) begin
                        cnt_n   = '0;
                        par_n   = rx_s;
                        state_n = STOP;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end

            STOP: begin
                if (baud_pulse) begin
                    if (cnt == FULL) begin
                        cnt_n  = '0;
                        push_n = 1'b1;
                        dout_n = shift;
                        pe_n   = cfg.pen && (par_q != parity_bit(shift, cfg.eps, cfg.sticky));
                        fe_n   = ~rx_s;
                        bi_n   = (shift == 8'h00) && (!cfg.pen || !par_q) && !rx_s;
                        // An edge coinciding with the stop sample still opens the next frame
                        if (fall) begin
                            state_n = START;
                            cfg_n   = cfg_in;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_top.sv
// Self-checking bench for uart_rx_top: table of frames plus hand-written
// false-start, reset and break sequences, checked through a scoreboard queue.
module tb_uart_rx_top;

    import uart_pkg::*;

    localparam int BIT_CLKS = 96;

    typedef struct {
        string      name;
        logic [7:0] ch;
        logic       pen;
        logic       eps;
        logic       stk;
        logic [1:0] wls;
        logic       par;
        logic       stop;
        int         idle_bits;
        logic [7:0] exp_dout;
        logic       exp_pe;
        logic       exp_fe;
        logic       exp_bi;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] dout;
        logic       pe;
        logic       fe;
        logic       bi;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_pulse = 1'b0;
    logic       rx;
    logic       pen, eps, sticky_parity;
    logic [1:0] wls;
    logic       push;
    logic [7:0] dout;
    logic       pe, fe, bi;

    int   checks     = 0;
    int   errors     = 0;
    int   push_count = 0;
    int   bdiv       = 0;
    exp_t sb[$];
    vec_t vecs[10];

    uart_rx_top #(
        .OVERSAMPLE (16),
        .SYNC_STAGES(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_pulse   (baud_pulse),
        .rx           (rx),
        .pen          (pen),
        .eps          (eps),
        .sticky_parity(sticky_parity),
        .wls          (wls),
        .push         (push),
        .dout         (dout),
        .pe           (pe),
        .fe           (fe),
        .bi           (bi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bdiv == 5) begin
            bdiv       <= 0;
            baud_pulse <= 1'b1;
        end else begin
            bdiv       <= bdiv + 1;
            baud_pulse <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic waitClks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every push is matched against the oldest outstanding frame
    always @(negedge clk) begin
        exp_t e;
        if (push) begin
            push_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_push: got push with dout=%0h, expected none", dout);
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, ".dout"}, 32'(dout), 32'(e.dout));
                checkOutput({e.name, ".pe"}, 32'(pe), 32'(e.pe));
                checkOutput({e.name, ".fe"}, 32'(fe), 32'(e.fe));
                checkOutput({e.name, ".bi"}, 32'(bi), 32'(e.bi));
            end
        end
    end

    // Serialises one frame; config inputs are scrambled after the start bit
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        int   len;
        e.name = v.name;
        e.dout = v.exp_dout;
        e.pe   = v.exp_pe;
        e.fe   = v.exp_fe;
        e.bi   = v.exp_bi;
        sb.push_back(e);
        pen           = v.pen;
        eps           = v.eps;
        sticky_parity = v.stk;
        wls           = v.wls;
        len           = 5 + int'(v.wls);
        rx            = 1'b0;
        waitClks(BIT_CLKS);
        pen           = ~v.pen;
        eps           = ~v.eps;
        sticky_parity = ~v.stk;
        wls           = ~v.wls;
        for (int i = 0; i < len; i++) begin
            rx = v.ch[i];
            waitClks(BIT_CLKS);
        end
        if (v.pen) begin
            rx = v.par;
            waitClks(BIT_CLKS);
        end
        rx = v.stop;
        waitClks(BIT_CLKS);
        rx = 1'b1;
        waitClks(v.idle_bits * BIT_CLKS);
    endtask

    initial begin
        int pc0;
        logic [7:0] pre;

        vecs[0] = '{"par_ok",    8'h13, 1, 1, 0, 2'b11, 1, 1, 1, 8'h13, 0, 0, 0};
        vecs[1] = '{"par_bad",   8'h13, 1, 1, 0, 2'b11, 0, 1, 1, 8'h13, 1, 0, 0};
        vecs[2] = '{"sticky",    8'h13, 1, 1, 1, 2'b11, 0, 1, 1, 8'h13, 0, 0, 0};
        vecs[3] = '{"wls5_a",    8'h15, 0, 0, 0, 2'b00, 0, 1, 0, 8'h15, 0, 0, 0};
        vecs[4] = '{"wls5_b2b",  8'h0A, 0, 0, 0, 2'b00, 0, 1, 2, 8'h0A, 0, 0, 0};
        vecs[5] = '{"wls6_even", 8'hEA, 1, 1, 0, 2'b01, 1, 1, 1, 8'h2A, 0, 0, 0};
        vecs[6] = '{"wls6_odd",  8'h3F, 1, 0, 0, 2'b01, 1, 1, 1, 8'h3F, 0, 0, 0};
        vecs[7] = '{"stick_bad", 8'h00, 1, 0, 1, 2'b11, 0, 1, 1, 8'h00, 1, 0, 0};
        vecs[8] = '{"frame_err", 8'h7F, 0, 0, 0, 2'b10, 0, 0, 1, 8'h7F, 0, 1, 0};
        vecs[9] = '{"brk_frame", 8'h00, 1, 1, 0, 2'b11, 0, 0, 2, 8'h00, 0, 1, 1};

        rst           = 1'b1;
        rx            = 1'b1;
        pen           = 1'b0;
        eps           = 1'b0;
        sticky_parity = 1'b0;
        wls           = 2'b00;
        waitClks(4);
        checkOutput("rst_push", 32'(push), 0);
        checkOutput("rst_dout", 32'(dout), 0);
        checkOutput("rst_pe", 32'(pe), 0);
        checkOutput("rst_fe", 32'(fe), 0);
        checkOutput("rst_bi", 32'(bi), 0);
        rst = 1'b0;
        waitClks(2 * BIT_CLKS);

        for (int i = 0; i < 10; i++)
            applyStimulus(vecs[i]);

        // Short low pulse must be rejected as a false start
        pc0 = push_count;
        rx  = 1'b0;
        waitClks(24);
        rx  = 1'b1;
        waitClks(2 * BIT_CLKS);
        checkOutput("false_start_nopush", 32'(push_count), 32'(pc0));
        checkOutput("false_start_idle", 32'(dut.state), 32'(IDLE));
        applyStimulus('{"after_false", 8'hA5, 0, 0, 0, 2'b11, 0, 1, 2, 8'hA5, 0, 0, 0});

        // Reset during data bit 3 aborts the frame without a push
        pc0 = push_count;
        pen = 1'b0;
        wls = 2'b11;
        pre = 8'h33;
        rx  = 1'b0;
        waitClks(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rx = pre[i];
            waitClks(BIT_CLKS);
        end
        rx = pre[3];
        waitClks(BIT_CLKS / 2);
        rst = 1'b1;
        rx  = 1'b1;
        waitClks(1);
        checkOutput("midrst_push", 32'(push), 0);
        checkOutput("midrst_dout", 32'(dout), 0);
        checkOutput("midrst_pe", 32'(pe), 0);
        checkOutput("midrst_fe", 32'(fe), 0);
        checkOutput("midrst_bi", 32'(bi), 0);
        checkOutput("midrst_state", 32'(dut.state), 32'(IDLE));
        waitClks(2);
        rst = 1'b0;
        waitClks(2 * BIT_CLKS);
        checkOutput("midrst_nopush", 32'(push_count), 32'(pc0));
        applyStimulus('{"after_rst", 8'h5C, 0, 0, 0, 2'b11, 0, 1, 2, 8'h5C, 0, 0, 0});

        // Long break: one push only, no retrigger while the line stays low
        pc0           = push_count;
        pen           = 1'b1;
        eps           = 1'b1;
        sticky_parity = 1'b0;
        wls           = 2'b11;
        sb.push_back('{"break", 8'h00, 1'b0, 1'b1, 1'b1});
        rx = 1'b0;
        waitClks(12 * BIT_CLKS);
        checkOutput("break_one_push", 32'(push_count), 32'(pc0 + 1));
        rx = 1'b1;
        waitClks(3 * BIT_CLKS);
        checkOutput("break_after_high", 32'(push_count), 32'(pc0 + 1));

        checkOutput("sb_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
